// File: rtl/move_bar.sv
// Breakout paddle controller: conditions the push-keys, then steps the bar centre
// on a frame tick with a hold-to-accelerate ramp, clamped to the screen edges.
module move_bar #(
    parameter int SCREEN_W   = 640,
    parameter int W_BAR      = 64,
    parameter int Y_BAR      = 456,
    parameter int TICK_DIV   = 833333,
    parameter int DEB_CYCLES = 500000,
    parameter int V_MIN      = 2,
    parameter int V_MAX      = 8,
    parameter int RAMP_TICKS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       endgame,
    output logic [9:0] x_bar,
    output logic [9:0] y_bar,
    output logic [3:0] speed,
    output logic [1:0] moving
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);
    localparam logic [9:0]    LIM_L     = 10'(W_BAR);
    localparam logic [9:0]    LIM_R     = 10'(SCREEN_W - W_BAR);
    localparam logic [9:0]    X_MID     = 10'(SCREEN_W / 2);
    localparam logic [3:0]    V_MIN_C   = 4'(V_MIN);
    localparam logic [3:0]    V_MAX_C   = 4'(V_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVE_L = 2'b01,
        MOVE_R = 2'b10,
        FROZEN = 2'b11
    } state_t;

    // bit 0 = left, bit 1 = right, bit 2 = start; 1 means pressed
    logic [2:0]         keys_s;
    logic [2:0]         sync1_r;
    logic [2:0]         sync2_r;
    logic [2:0]         deb_r;
    logic [2:0][DW-1:0] deb_cnt_r;
    logic [TW-1:0]      tick_cnt_r;
    logic               tick_s;
    state_t             state_r;
    logic [9:0]         x_bar_r;
    logic [3:0]         speed_r;
    logic [RW-1:0]      ramp_r;
    logic [1:0]         moving_r;
    logic [9:0]         x_left_s;
    logic [9:0]         x_right_s;
    logic [3:0]         speed_next_s;
    logic [RW-1:0]      ramp_next_s;
    logic               l_s;
    logic               r_s;
    logic               s_s;

    assign keys_s = {~start, ~key_right, ~key_left};
    assign l_s    = deb_r[0];
    assign r_s    = deb_r[1];
    assign s_s    = deb_r[2];
    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Two-flop synchronisers and per-key debounce counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 3'b000;
            sync2_r   <= 3'b000;
            deb_r     <= 3'b000;
            deb_cnt_r <= {3{{DW{1'b0}}}};
        end else begin
            sync1_r <= keys_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                end
            end
        end
    end

    // Free-running frame tick divider.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Clamp is decided before the subtract/add so the position never wraps.
    always_comb begin
        x_left_s     = ((x_bar_r - LIM_L) < {6'b000000, speed_r}) ? LIM_L : (x_bar_r - {6'b000000, speed_r});
        x_right_s    = ((LIM_R - x_bar_r) < {6'b000000, speed_r}) ? LIM_R : (x_bar_r + {6'b000000, speed_r});
        ramp_next_s  = (ramp_r == RAMP_LAST) ? {RW{1'b0}} : (ramp_r + RW'(1));
        speed_next_s = speed_r;
        if (ramp_r == RAMP_LAST) begin
            speed_next_s = (speed_r >= V_MAX_C) ? V_MAX_C : (speed_r + 4'd1);
        end else begin
            speed_next_s = speed_r;
        end
    end

    // Paddle state machine: start recentres, endgame freezes, keys move.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            x_bar_r  <= X_MID;
            speed_r  <= V_MIN_C;
            ramp_r   <= {RW{1'b0}};
            moving_r <= 2'b00;
        end else if (s_s) begin
            state_r  <= IDLE;
            x_bar_r  <= X_MID;
            speed_r  <= V_MIN_C;
            ramp_r   <= {RW{1'b0}};
            moving_r <= 2'b00;
        end else if (endgame) begin
            state_r  <= FROZEN;
            moving_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    speed_r <= V_MIN_C;
                    ramp_r  <= {RW{1'b0}};
                    if (l_s && !r_s) begin
                        state_r  <= MOVE_L;
                        moving_r <= 2'b01;
                    end else if (r_s && !l_s) begin
                        state_r  <= MOVE_R;
                        moving_r <= 2'b10;
                    end else begin
                        state_r  <= IDLE;
                        moving_r <= 2'b00;
                    end
                end
                MOVE_L: begin
                    if (!l_s || r_s) begin
                        state_r  <= IDLE;
                        speed_r  <= V_MIN_C;
                        ramp_r   <= {RW{1'b0}};
                        moving_r <= 2'b00;
                    end else if (tick_s) begin
                        x_bar_r <= x_left_s;
                        speed_r <= speed_next_s;
                        ramp_r  <= ramp_next_s;
                    end else begin
                        state_r <= MOVE_L;
                    end
                end
                MOVE_R: begin
                    if (!r_s || l_s) begin
                        state_r  <= IDLE;
                        speed_r  <= V_MIN_C;
                        ramp_r   <= {RW{1'b0}};
                        moving_r <= 2'b00;
                    end else if (tick_s) begin
                        x_bar_r <= x_right_s;
                        speed_r <= speed_next_s;
                        ramp_r  <= ramp_next_s;
                    end else begin
                        state_r <= MOVE_R;
                    end
                end
                FROZEN: begin
                    state_r  <= FROZEN;
                    moving_r <= 2'b00;
                end
                default: begin
                    state_r  <= IDLE;
                    moving_r <= 2'b00;
                end
            endcase
        end
    end

    assign x_bar  = x_bar_r;
    assign y_bar  = 10'(Y_BAR);
    assign speed  = speed_r;
    assign moving = moving_r;

endmodule

// File: doc/move_bar.md
# move_bar

Paddle controller for the Breakout datapath: turns the board's left/right push-keys into the bar centre coordinate (`x_bar`, `y_bar`) that the ball mover uses for bar-collision tests. It synchronises and debounces the keys, moves the bar on a frame-rate tick with a hold-to-accelerate speed ramp, and clamps the bar to the 640×480 screen. It recentres on `start` and freezes on `endgame`.

## Interface

Parameters:
- `SCREEN_W`, 640: screen width in pixels.
- `W_BAR`, 64: bar half-width. Centre limits are `LIM_L = W_BAR` (64) and `LIM_R = SCREEN_W - W_BAR` (576).
- `Y_BAR`, 456: fixed bar centre row.
- `TICK_DIV`, 833333: clock cycles per movement tick (60 Hz at 50 MHz).
- `DEB_CYCLES`, 500000: stable cycles required to accept a key level change (10 ms).
- `V_MIN`, 2: starting speed, in px/tick.
- `V_MAX`, 8: speed ceiling, in px/tick. Must not exceed 15.
- `RAMP_TICKS`, 8: number of move ticks at each speed before the speed increments.

Ports:
- `clock`, input, 1: system clock. The block uses one clock only; reset is asynchronous and active-low.
- `reset`, input, 1: asynchronous, active-low.
- `start`, input, 1: start key, active-low (0 = pressed).
- `key_left`, input, 1: left key, active-low.
- `key_right`, input, 1: right key, active-low.
- `endgame`, input, 1: driven by the ball mover; 1 = game over.
- `x_bar`, output, 10: bar centre x. Registered.
- `y_bar`, output, 10: bar centre y. Always equals `Y_BAR`.
- `speed`, output, 4: current speed, for the LEDs. Registered.
- `moving`, output, 2: `01` = moving left, `10` = moving right, `00` otherwise. Registered.

## Operation

Key conditioning:
- Each key passes through a 2-flop synchroniser, then a debouncer.
- The debounced level takes the synchronised value once that value has differed from the current debounced level for `DEB_CYCLES` consecutive cycles.
- Any cycle where the values match clears the debounce counter.
- The debounced levels are named L, R and S; each is 1 when its key is pressed.

Tick generator:
- A free-running counter from 0 to `TICK_DIV-1`.
- `tick` is high for the one cycle in which the count equals `TICK_DIV-1`.

State machine (states IDLE, MOVE_L, MOVE_R, FROZEN). Conditions are evaluated in the priority order below.
1. S=1, from any state: `x_bar`←`SCREEN_W/2`, speed←`V_MIN`, ramp←0, next state IDLE. This holds for every cycle in which S=1.
2. `endgame`=1, from any state other than case 1: next state FROZEN. Position and speed are held.
3. FROZEN: the state is held. Only case 1 exits it.
4. IDLE:
   - L=1 and R=0 → MOVE_L.
   - R=1 and L=0 → MOVE_R.
   - Otherwise, stay in IDLE.
   - speed stays at `V_MIN` and ramp stays at 0.
5. MOVE_L:
   - If L=0 or R=1, go to IDLE, set speed←`V_MIN` and ramp←0, and do not move on this cycle even if `tick`=1.
   - Otherwise, on `tick`:
     - If `x_bar - LIM_L < speed`, set `x_bar`←`LIM_L`; else `x_bar`←`x_bar - speed`.
     - If ramp=`RAMP_TICKS-1`, set ramp←0 and speed←min(speed+1, `V_MAX`); else ramp←ramp+1.
6. MOVE_R: the mirror of MOVE_L.
   - The exit condition is R=0 or L=1.
   - The clamp test is `LIM_R - x_bar < speed` → `LIM_R`; otherwise `x_bar`←`x_bar + speed`.

Arithmetic and boundary rules:
- The clamp compare is done before the add/subtract, so `x_bar` never wraps and never leaves [`LIM_L`, `LIM_R`].
- At a wall with the key still held:
  - the state stays MOVE_x;
  - `x_bar` stays pinned at the limit;
  - the speed ramp continues.
- Reversing direction always passes through IDLE for at least one cycle, and the speed restarts at `V_MIN`.
- `moving` decodes the current state; it is `00` in IDLE and FROZEN.

## Timing

Reset values (asynchronous, `reset`=0):
- `x_bar`=320, `y_bar`=`Y_BAR`, `speed`=`V_MIN`, `moving`=`00`, state IDLE.
- Tick counter, debounce counters and synchronisers: 0. A synchroniser output of 0 means "released".

Reset asserted mid-move returns every output to these values immediately. The first tick after release comes `TICK_DIV` cycles later.

Latencies:
- Key edge to debounced level: 2 + `DEB_CYCLES` cycles.
- Debounced level to state change: 1 cycle.
- `tick` to new `x_bar`/`speed`: 1 cycle (both registered on the tick cycle's clock edge).
- `endgame` rise to FROZEN: 1 cycle. `x_bar` does not change on that edge, even if `tick`=1.

## Test plan

All scenarios use `TICK_DIV`=4, `DEB_CYCLES`=3, `V_MIN`=2, `V_MAX`=4, `RAMP_TICKS`=2.

- **Reset and idle.** Assert `reset`=0 mid-run → `x_bar`=320, `speed`=2, `moving`=00 asynchronously. With no keys pressed for 40 cycles, `x_bar` stays at 320.
- **Ramp.** Hold `key_left`=0 → `moving`=01 after 6 cycles. Across successive ticks, `x_bar` goes 318, 316, 313, 310, 306, 302, with `speed` rising 2→3→4 and holding at 4.
- **Wall clamp.** Start at `x_bar`=67 with speed 4 and left held → the next tick gives 64, and further ticks stay at 64. The mirrored case: from 574 moving right → 576.
- **Both keys and glitch.** A 2-cycle press of `key_right` produces no state change. Pressing both keys forces IDLE, `moving`=00, `speed`=2, and `x_bar` is unchanged even when release and tick fall on the same cycle.
- **Endgame.** Raise `endgame` while in MOVE_R → FROZEN. `x_bar` is constant through 10 ticks and the arrow keys are ignored. Pulsing `start` low for 6 cycles → `x_bar`=320, state IDLE.
- **Start priority.** Hold `start` and `key_left` together → `x_bar` stays at 320 for as long as S=1. After `start` is released, the bar moves left on the following ticks.
